// File: rtl/reduction_thresholds_pkg.sv
// Shared constants for the colour-reduction threshold register bank.
// Channel addresses, field widths and the reset exponent code.
package reduction_thresholds_pkg;

  localparam int W_OUT_DEF      = 8;
  localparam int W_IN_DEF       = 3;
  localparam int RESET_CODE_DEF = 0;

  typedef enum logic [1:0] {
    CH_HUE  = 2'b00,
    CH_SAT  = 2'b01,
    CH_VAL  = 2'b10,
    CH_RSVD = 2'b11
  } ch_e;

endpackage

// File: rtl/reduction_thresholds_decode.sv
// Combinational exponent-to-threshold decoder: o_thr = 1 << i_code.
// The result is one-hot, so it is never zero.
module threshold_decode
  import reduction_thresholds_pkg::*;
#(
  parameter int W_OUT = W_OUT_DEF,
  parameter int W_IN  = W_IN_DEF
) (
  input  logic [W_IN-1:0]  i_code,
  output logic [W_OUT-1:0] o_thr
);

  // NOTE: default assignment first so every path drives o_thr and no latch is inferred.
  always_comb begin
    o_thr         = '0;
    o_thr[i_code] = 1'b1;
  end

endmodule

// File: rtl/reduction_thresholds.sv
// Per-channel (H/S/V) quantisation threshold registers with addressed writes.
// Outputs come straight from flops; selector 2'b11 is a silent no-op.
module reduction_thresholds
  import reduction_thresholds_pkg::*;
#(
  parameter int W_OUT      = W_OUT_DEF,
  parameter int W_IN       = W_IN_DEF,
  parameter int RESET_CODE = RESET_CODE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             select,
  input  logic [1:0]       selector,
  input  logic [W_IN-1:0]  inputVal,
  output logic [W_OUT-1:0] hThreshold,
  output logic [W_OUT-1:0] sThreshold,
  output logic [W_OUT-1:0] vThreshold
);

  localparam logic [W_OUT-1:0] RESET_THR = W_OUT'(1) << RESET_CODE;

  logic [W_OUT-1:0] w_thr;
  logic             w_we_h;
  logic             w_we_s;
  logic             w_we_v;
  ch_e              w_ch;

  logic [W_OUT-1:0] r_h;
  logic [W_OUT-1:0] r_s;
  logic [W_OUT-1:0] r_v;

  threshold_decode #(
    .W_OUT (W_OUT),
    .W_IN  (W_IN)
  ) u_decode (
    .i_code (inputVal),
    .o_thr  (w_thr)
  );

  assign w_ch   = ch_e'(selector);
  assign w_we_h = select && (w_ch == CH_HUE);
  assign w_we_s = select && (w_ch == CH_SAT);
  assign w_we_v = select && (w_ch == CH_VAL);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h <= RESET_THR;
      r_s <= RESET_THR;
      r_v <= RESET_THR;
    end else begin
      if (w_we_h) r_h <= w_thr;
      if (w_we_s) r_s <= w_thr;
      if (w_we_v) r_v <= w_thr;
    end
  end

  assign hThreshold = r_h;
  assign sThreshold = r_s;
  assign vThreshold = r_v;

endmodule

// File: tb/tb_reduction_thresholds.sv
// Scoreboard bench for reduction_thresholds: expected state is queued per
// driven cycle and compared one edge later.
module tb_reduction_thresholds;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] s;
    logic [7:0] v;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       select;
  logic [1:0] selector;
  logic [2:0] inputVal;
  logic [7:0] hThreshold;
  logic [7:0] sThreshold;
  logic [7:0] vThreshold;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t q_exp[$];
  exp_t m;

  always #5 clk = ~clk;

  reduction_thresholds dut (
    .clk        (clk),
    .reset      (reset),
    .select     (select),
    .selector   (selector),
    .inputVal   (inputVal),
    .hThreshold (hThreshold),
    .sThreshold (sThreshold),
    .vThreshold (vThreshold)
  );

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drive one cycle, update the model, queue its prediction, then compare after the edge.
  task automatic step(input logic rst, input logic sel, input logic [1:0] ch, input logic [2:0] val);
    logic [7:0] thr;
    exp_t       e;
    @(negedge clk);
    reset    = rst;
    select   = sel;
    selector = ch;
    inputVal = val;
    thr = 8'd1 << val;
    if (rst) begin
      m = '{h: 8'd1, s: 8'd1, v: 8'd1};
    end else if (sel) begin
      case (ch)
        2'b00:   m.h = thr;
        2'b01:   m.s = thr;
        2'b10:   m.v = thr;
        default: ;
      endcase
    end
    q_exp.push_back(m);
    @(posedge clk);
    #1;
    if (q_exp.size() == 0) begin
      check("queue_empty", 8'd0, 8'd1);
    end else begin
      e = q_exp.pop_front();
      check("h", hThreshold, e.h);
      check("s", sThreshold, e.s);
      check("v", vThreshold, e.v);
    end
  endtask

  initial begin
    reset = 1'b0; select = 1'b0; selector = 2'b00; inputVal = 3'd0;
    m = '{h: 8'd1, s: 8'd1, v: 8'd1};

    // 1: reset
    step(1'b1, 1'b0, 2'b00, 3'd0);
    step(1'b0, 1'b0, 2'b00, 3'd0);
    check("reset_h", hThreshold, 8'd1);
    check("reset_s", sThreshold, 8'd1);
    check("reset_v", vThreshold, 8'd1);

    // 2: write saturation
    step(1'b0, 1'b1, 2'b01, 3'd5);
    step(1'b0, 1'b0, 2'b01, 3'd5);
    check("sat_32", sThreshold, 8'd32);

    // 3: hue then value
    step(1'b0, 1'b1, 2'b00, 3'd1);
    step(1'b0, 1'b1, 2'b10, 3'd7);
    check("hue_2", hThreshold, 8'd2);
    check("val_128", vThreshold, 8'd128);
    check("sat_hold", sThreshold, 8'd32);

    // 4: select low holds everything
    for (int c = 0; c < 4; c++)
      for (int n = 0; n < 8; n++)
        step(1'b0, 1'b0, 2'(c), 3'(n));

    // 5: reserved channel is a no-op, then reset beats select
    step(1'b0, 1'b1, 2'b11, 3'd6);
    check("rsvd_h", hThreshold, 8'd2);
    check("rsvd_v", vThreshold, 8'd128);
    step(1'b1, 1'b1, 2'b10, 3'd4);
    check("rst_wins_v", vThreshold, 8'd1);

    // 6: continuous writes, no edge detection
    step(1'b0, 1'b1, 2'b00, 3'd0);
    step(1'b0, 1'b1, 2'b00, 3'd3);
    check("burst_h8", hThreshold, 8'd8);
    step(1'b0, 1'b1, 2'b00, 3'd7);
    check("burst_h128", hThreshold, 8'd128);

    // Full decode sweep on every channel
    for (int c = 0; c < 3; c++)
      for (int n = 0; n < 8; n++)
        step(1'b0, 1'b1, 2'(c), 3'(n));
    step(1'b0, 1'b0, 2'b00, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
